// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state encoding and 32-bit round/schedule functions.
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_chunk_core_msg_schedule.sv
// 16-word sliding message schedule window; w_cur is the word consumed by the current round.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] chunk_in,
  output logic [31:0]  w_cur
);

  logic [31:0] w [16];
  logic [31:0] w_next;

  assign w_next = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
  assign w_cur  = w[0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) w[i] <= chunk_in[511 - 32*i -: 32];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_next;
    end
  end

endmodule

// File: rtl/sha256_chunk_core.sv
// Iterative SHA-256 compression: one round per clock, running digest carried across chunks.
//   state    | meaning
//   ST_IDLE  | waiting for a chunk; chunk_ready=1
//   ST_ROUND | rounds 0..63, one per clock
//   ST_FINAL | fold working vars into H, publish digest and target flag
module sha256_chunk_core
  import sha256_pkg::*;
#(
  parameter int ZERO_BITS = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [511:0] chunk_in,
  input  logic         chunk_valid,
  input  logic         first_chunk,
  output logic         chunk_ready,
  output logic         busy,
  output logic [255:0] hash_out,
  output logic         hash_valid,
  output logic         hash_meets_target
);

  state_t      state;
  logic [5:0]  round;
  logic [31:0] wk    [8];
  logic [31:0] h_acc [8];
  logic [31:0] w_cur;
  logic [31:0] t1;
  logic [31:0] t2;
  logic [255:0] digest_next;
  logic        meets_next;
  logic        accept;

  assign accept = (state == ST_IDLE) && chunk_valid;

  sha256_msg_schedule u_sched (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .shift    (state == ST_ROUND),
    .chunk_in (chunk_in),
    .w_cur    (w_cur)
  );

  assign t1 = wk[7] + big_sigma1(wk[4]) + ch(wk[4], wk[5], wk[6]) + K[round] + w_cur;
  assign t2 = big_sigma0(wk[0]) + maj(wk[0], wk[1], wk[2]);

  assign digest_next = {h_acc[0] + wk[0], h_acc[1] + wk[1], h_acc[2] + wk[2], h_acc[3] + wk[3],
                        h_acc[4] + wk[4], h_acc[5] + wk[5], h_acc[6] + wk[6], h_acc[7] + wk[7]};
  assign meets_next  = (digest_next[255 -: ZERO_BITS] == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= ST_IDLE;
      round             <= '0;
      hash_out          <= '0;
      hash_valid        <= 1'b0;
      hash_meets_target <= 1'b0;
      chunk_ready       <= 1'b1;
      busy              <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        wk[i]    <= '0;
        h_acc[i] <= IV[i];
      end
    end else begin
      hash_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (chunk_valid) begin
            for (int i = 0; i < 8; i++) begin
              wk[i] <= first_chunk ? IV[i] : h_acc[i];
              if (first_chunk) h_acc[i] <= IV[i];
            end
            round       <= '0;
            state       <= ST_ROUND;
            chunk_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        ST_ROUND: begin
          wk[7] <= wk[6];
          wk[6] <= wk[5];
          wk[5] <= wk[4];
          wk[4] <= wk[3] + t1;
          wk[3] <= wk[2];
          wk[2] <= wk[1];
          wk[1] <= wk[0];
          wk[0] <= t1 + t2;
          if (round == 6'd63) state <= ST_FINAL;
          else                round <= round + 6'd1;
        end
        ST_FINAL: begin
          for (int i = 0; i < 8; i++) h_acc[i] <= digest_next[255 - 32*i -: 32];
          hash_out          <= digest_next;
          hash_valid        <= 1'b1;
          hash_meets_target <= meets_next;
          state             <= ST_IDLE;
          chunk_ready       <= 1'b1;
          busy              <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
